// File: rtl/oser4_stream.sv
// oser4_stream: 4-to-1 streaming serializer with a ready/valid load port.
// A word is taken when CE, LOAD_VALID and LOAD_READY are all high. Its four
// bits then leave on Q over four CE-qualified cycles, and Q_FIRST marks the
// first bit. A new word can be loaded on the edge that ends the last bit, so
// consecutive words stream with no gap in Q_VALID.
//
// state | meaning
// IDLE  | no word in flight; Q holds INIT; ready for a word
// SHIFT | Q carries bit cnt_q of the current word; ready only at cnt_q == 3
module oser4_stream #(
  parameter logic INIT      = 1'b0,
  parameter logic LSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       LOAD_VALID,
  output logic       LOAD_READY,
  input  logic [3:0] D,
  output logic       Q,
  output logic       Q_VALID,
  output logic       Q_FIRST
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Declaration initialisers give the power-up state for runs without reset.
  state_t     state_q = IDLE;
  logic [3:0] sr_q    = 4'b0000;
  logic [1:0] cnt_q   = 2'd0;
  logic       q_q     = INIT;
  logic       qv_q    = 1'b0;
  logic       qf_q    = 1'b0;

  logic [3:0] load_word_d;
  logic       load_accept_d;

  // Reorder the incoming word so that bit 0 is always the first bit sent.
  always_comb begin
    load_word_d = LSB_FIRST ? D : {D[0], D[1], D[2], D[3]};
  end

  // Ready comes only from registered state; acceptance also needs CE.
  always_comb begin
    LOAD_READY    = (state_q == IDLE) || (cnt_q == 2'd3);
    load_accept_d = CE && LOAD_VALID && LOAD_READY;
  end

  // Serializer FSM; reset overrides CE and any word offered on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      sr_q    <= 4'b0000;
      q_q     <= INIT;
      qv_q    <= 1'b0;
      qf_q    <= 1'b0;
    end else if (CE) begin
      if (load_accept_d) begin
        // The first bit goes straight to Q. The other three wait in sr_q,
        // with the next bit to send at position 0.
        state_q <= SHIFT;
        cnt_q   <= 2'd0;
        q_q     <= load_word_d[0];
        sr_q    <= {1'b0, load_word_d[3:1]};
        qv_q    <= 1'b1;
        qf_q    <= 1'b1;
      end else if (state_q == SHIFT) begin
        if (cnt_q == 2'd3) begin
          state_q <= IDLE;
          cnt_q   <= 2'd0;
          sr_q    <= 4'b0000;
          q_q     <= INIT;
          qv_q    <= 1'b0;
          qf_q    <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 2'd1;
          q_q   <= sr_q[0];
          sr_q  <= {1'b0, sr_q[3:1]};
          qf_q  <= 1'b0;
        end
      end
    end
  end

  assign Q       = q_q;
  assign Q_VALID = qv_q;
  assign Q_FIRST = qf_q;

endmodule

// File: tb/tb_oser4_stream.sv
// Bench for oser4_stream. It drives two instances from the same stimulus:
// A uses INIT=0 with LSB first, and B uses INIT=1 with MSB first.
// The reference model is a queue of the bits each instance still has to show.
// Whenever the model accepts a word, the driver pushes that word's four bits.
// At every CE edge the monitor pops one bit, or expects idle if the queue is
// empty. Ready is expected exactly when nothing is left queued.
module tb_oser4_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic       lv  = 1'b0;
  logic [3:0] d   = 4'h0;

  logic rdy_a, q_a, qv_a, qf_a;
  logic rdy_b, q_b, qv_b, qf_b;

  oser4_stream #(.INIT(1'b0), .LSB_FIRST(1'b1)) dut_a (
    .CLK(clk), .RESET(rst), .CE(ce), .LOAD_VALID(lv), .LOAD_READY(rdy_a),
    .D(d), .Q(q_a), .Q_VALID(qv_a), .Q_FIRST(qf_a)
  );

  oser4_stream #(.INIT(1'b1), .LSB_FIRST(1'b0)) dut_b (
    .CLK(clk), .RESET(rst), .CE(ce), .LOAD_VALID(lv), .LOAD_READY(rdy_b),
    .D(d), .Q(q_b), .Q_VALID(qv_b), .Q_FIRST(qf_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic q;
    logic first;
  } bit_t;

  bit_t sb_a[$];
  bit_t sb_b[$];

  int checks   = 0;
  int failures = 0;
  int accepted = 0;

  // What each output should currently show.
  logic eq_a = 1'b0, ev_a = 1'b0, ef_a = 1'b0;
  logic eq_b = 1'b1, ev_b = 1'b0, ef_b = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at time %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on each rising edge, work out what the outputs must show next.
  initial begin : monitor
    logic ce_e, rst_e;
    bit_t e;
    forever begin
      @(posedge clk);
      ce_e  = ce;
      rst_e = rst;
      #1;
      if (rst_e) begin
        sb_a.delete();
        sb_b.delete();
        eq_a = 1'b0; ev_a = 1'b0; ef_a = 1'b0;
        eq_b = 1'b1; ev_b = 1'b0; ef_b = 1'b0;
      end else if (ce_e) begin
        if (sb_a.size() > 0) begin
          e = sb_a.pop_front();
          eq_a = e.q; ev_a = 1'b1; ef_a = e.first;
        end else begin
          eq_a = 1'b0; ev_a = 1'b0; ef_a = 1'b0;
        end
        if (sb_b.size() > 0) begin
          e = sb_b.pop_front();
          eq_b = e.q; ev_b = 1'b1; ef_b = e.first;
        end else begin
          eq_b = 1'b1; ev_b = 1'b0; ef_b = 1'b0;
        end
      end
      chk("a_q", q_a, eq_a);
      chk("a_q_valid", qv_a, ev_a);
      chk("a_q_first", qf_a, ef_a);
      chk("b_q", q_b, eq_b);
      chk("b_q_valid", qv_b, ev_b);
      chk("b_q_first", qf_b, ef_b);
    end
  end

  // One cycle of stimulus: check ready, drive inputs, and push any accepted word.
  task automatic cycle(input logic ce_v, input logic rst_v, input logic lv_v,
                       input logic [3:0] d_v);
    bit_t e;
    @(negedge clk);
    chk("a_load_ready", rdy_a, sb_a.size() == 0);
    chk("b_load_ready", rdy_b, sb_b.size() == 0);
    ce  = ce_v;
    rst = rst_v;
    lv  = lv_v;
    d   = d_v;
    if (ce_v && !rst_v && lv_v && sb_a.size() == 0) begin
      accepted++;
      for (int i = 0; i < 4; i++) begin
        e.q = d_v[i];
        e.first = (i == 0);
        sb_a.push_back(e);
      end
    end
    if (ce_v && !rst_v && lv_v && sb_b.size() == 0) begin
      for (int i = 0; i < 4; i++) begin
        e.q = d_v[3-i];
        e.first = (i == 0);
        sb_b.push_back(e);
      end
    end
  endtask

  initial begin : driver
    // Power-up values, before the first clock edge.
    #1;
    chk("pwr_q_a", q_a, 1'b0);
    chk("pwr_q_b", q_b, 1'b1);
    chk("pwr_valid_a", qv_a, 1'b0);
    chk("pwr_first_b", qf_b, 1'b0);
    chk("pwr_ready_a", rdy_a, 1'b1);
    chk("pwr_ready_b", rdy_b, 1'b1);

    repeat (3) cycle(1'b1, 1'b1, 1'b0, 4'h0);

    // Single word 1011.
    cycle(1'b1, 1'b0, 1'b1, 4'b1011);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 4'($urandom));

    // Back to back: A, then 5 offered until it is taken.
    cycle(1'b1, 1'b0, 1'b1, 4'hA);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 4'h5);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 4'h0);

    // Stop CE for three cycles after the second bit.
    cycle(1'b1, 1'b0, 1'b1, 4'b0110);
    cycle(1'b1, 1'b0, 1'b0, 4'hF);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 4'($urandom));
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 4'($urandom));

    // Reset on the edge after the second bit.
    cycle(1'b1, 1'b0, 1'b1, 4'b1101);
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b1, 1'b0, 4'h0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 4'h0);

    // Reset and a load on the same edge; then reset with CE low during a word.
    cycle(1'b1, 1'b1, 1'b1, 4'hC);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 1'b1, 4'h9);
    cycle(1'b0, 1'b1, 1'b1, 4'h3);
    cycle(1'b1, 1'b0, 1'b1, 4'h3);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 4'h0);

    // Random traffic.
    repeat (2000) begin
      cycle(($urandom % 8) != 0, ($urandom % 64) == 0, ($urandom % 3) != 0,
            4'($urandom));
    end
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 4'h0);

    if (accepted < 20) begin
      failures++;
      $display("FAIL accept_count: got %0d expected at least 20", accepted);
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
